sparc_ifu_starv_mon: RTL and testbench
======================================

# sparc_ifu_starv_mon

Parametrised multi-thread starvation monitor for the IFU thread-select path. One saturating wait counter per thread counts consecutive cycles in which the thread is ready but not granted. A thread whose count reaches a runtime-programmable limit is flagged starving. A round-robin pick among starving threads drives a one-hot fairness override back into the thread-select logic.

## Interface
Parameters:
- NUM_THR, 4, number of monitored threads (≥2)
- CTR_W, 5, width of each wait counter and of the limit register
- DEF_LIMIT, 24, limit value loaded at reset (must be < 2^CTR_W)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- thr_wait  input  NUM_THR  thread i is ready to issue this cycle
- thr_grant  input  NUM_THR  thread i was selected this cycle (may be multi-hot)
- limit_wr_en  input  1  load limit register
- limit_wr_data  input  CTR_W  new limit value
- clr_seen  input  1  clear all starv_seen bits
- starv  output  NUM_THR  count[i] ≥ limit and limit ≠ 0
- starv_pick  output  NUM_THR  one-hot (or zero) round-robin choice among starving threads
- any_starv  output  1  OR of starv
- starv_seen  output  NUM_THR  sticky record that starv[i] was ever set
- limit  output  CTR_W  current limit register value

## Operation
- Per-thread counter update, evaluated in priority order:
  - reset → 0.
  - thr_grant[i] → 0. Grant wins over wait.
  - !thr_wait[i] → 0. A wait must be consecutive to count.
  - thr_wait[i] → count+1, saturating at 2^CTR_W−1 (no wrap).
- Limit register:
  - reset → DEF_LIMIT.
  - limit_wr_en → limit_wr_data.
  - A limit of 0 disables detection: starv, starv_pick and any_starv are all 0.
- starv[i] is combinational from the count and limit registers. There is no hysteresis. It drops the cycle after the counter clears.
- Round-robin pointer rr_ptr, log2(NUM_THR) bits:
  - reset → 0.
  - starv_pick selects the first i with starv[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_THR.
  - When starv_pick is non-zero and thr_grant for the picked thread is 1, rr_ptr ← (picked index + 1) mod NUM_THR. Otherwise rr_ptr holds.
- starv_seen[i]:
  - reset or clr_seen → 0.
  - Otherwise starv_seen[i] ← starv_seen[i] | starv[i].
  - If clr_seen and starv[i] occur in the same cycle, the set wins, so starv_seen[i]=1.
- A limit write while counters are above the new value flags those threads on the next cycle. Counters are not modified by the write.

## Timing
- All outputs are 0 the cycle after reset, except limit = DEF_LIMIT.
- With counter at 0, N consecutive edges with thr_wait=1 and thr_grant=0 give count=N.
- starv rises in the cycle after the edge on which count reaches limit. With the default limit, that is after 24 consecutive wait cycles.
- thr_grant sampled at edge k: count=0, and starv deasserts, from cycle k+1.
- limit_wr_en at edge k: the new limit is used for comparison from cycle k+1.
- starv_pick, any_starv and starv are 0-latency functions of registered state. They carry no combinational path from any input.
- A reset asserted mid-operation clears all counters, rr_ptr and starv_seen on that edge, irrespective of the other inputs.
- Saturation: a counter at 2^CTR_W−1 with thr_wait=1 holds. starv stays asserted as long as limit ≠ 0.

## Test plan
- Default limit, thread 0:
  - 23 wait cycles → starv=0.
  - 24th wait cycle → starv[0]=1, starv_pick=0001, starv_seen[0]=1.
  - Grant → starv[0]=0 next cycle, starv_seen[0] stays 1.
- Wait broken by one idle cycle (thr_wait=0) at count 20 → count=0; a further 24 waits are needed before starv asserts.
- Round-robin:
  - Set limit=2 and starve threads 1 and 3 together → starv_pick=0010.
  - Grant thread 1 → rr_ptr=2 and thread 1 counter clears.
  - Keep thread 3 waiting → starv_pick=1000.
  - Grant thread 3 → pointer wraps to 0.
- Saturation and limit edge cases:
  - CTR_W=5, wait 40 cycles → count=31, starv=1.
  - Write limit=0 → starv=0 and starv_pick=0 next cycle.
  - Write limit=31 → starv=1 next cycle.
- Simultaneous events:
  - thr_grant and thr_wait both 1 for a thread → count=0.
  - clr_seen asserted while starv[2]=1 → starv_seen[2] remains 1.
- Reset mid-run with two threads starving → next cycle all outputs 0 except limit=DEF_LIMIT, including a previously programmed limit.

Source files
------------

// File: rtl/sparc_ifu_starv_mon.sv
// Starvation monitor for the IFU thread-select path: per-thread saturating wait
// counters, a programmable starvation limit and a round-robin fairness override.
module sparc_ifu_starv_mon #(
  parameter int NUM_THR   = 4,
  parameter int CTR_W     = 5,
  parameter int DEF_LIMIT = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_THR-1:0] thr_wait,
  input  logic [NUM_THR-1:0] thr_grant,
  input  logic               limit_wr_en,
  input  logic [CTR_W-1:0]   limit_wr_data,
  input  logic               clr_seen,
  output logic [NUM_THR-1:0] starv,
  output logic [NUM_THR-1:0] starv_pick,
  output logic               any_starv,
  output logic [NUM_THR-1:0] starv_seen,
  output logic [CTR_W-1:0]   limit
);

  localparam int PTR_W = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_THR - 1);
  localparam logic [PTR_W:0]   NUM_THR_X = (PTR_W + 1)'(NUM_THR);

  logic [CTR_W-1:0] count [NUM_THR];
  logic [CTR_W-1:0] limit_q;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the counter array is small and must start at
  // zero, so it is reset along with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THR; i++) count[i] <= '0;
      limit_q    <= CTR_W'(DEF_LIMIT);
      rr_ptr     <= '0;
      starv_seen <= '0;
    end else begin
      for (int i = 0; i < NUM_THR; i++) begin
        if (thr_grant[i] || !thr_wait[i]) count[i] <= '0;
        else if (count[i] != '1)          count[i] <= count[i] + CTR_W'(1);
      end
      if (limit_wr_en) limit_q <= limit_wr_data;
      // Advance past the serviced thread only once the override was honoured.
      if (pick_vld && thr_grant[pick_idx])
        rr_ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + PTR_W'(1);
      // A starving thread in the clear cycle stays recorded.
      starv_seen <= (clr_seen ? '0 : starv_seen) | starv;
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_THR; i++)
      starv[i] = (limit_q != '0) && (count[i] >= limit_q);
  end

  assign any_starv = |starv;
  assign limit     = limit_q;

  // First starving thread at or after rr_ptr, scanning modulo NUM_THR.
  always_comb begin
    logic [PTR_W:0] pos;
    pos        = '0;
    pick_vld   = 1'b0;
    pick_idx   = '0;
    starv_pick = '0;
    for (int k = 0; k < NUM_THR; k++) begin
      pos = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (pos >= NUM_THR_X) pos = pos - NUM_THR_X;
      if (!pick_vld && starv[pos[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = pos[PTR_W-1:0];
      end
    end
    for (int i = 0; i < NUM_THR; i++)
      starv_pick[i] = pick_vld && (pick_idx == PTR_W'(i));
  end

endmodule

// File: tb/tb_sparc_ifu_starv_mon.sv
// Self-checking bench for sparc_ifu_starv_mon (NUM_THR=4, CTR_W=5, DEF_LIMIT=24).
// Expected output bundles are queued as stimulus is applied and compared after the edge.
module tb_sparc_ifu_starv_mon;

  typedef struct packed {
    logic [3:0] starv;
    logic [3:0] pick;
    logic       any;
    logic [3:0] seen;
    logic [4:0] limit;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] thr_wait = '0;
  logic [3:0] thr_grant = '0;
  logic       limit_wr_en = 1'b0;
  logic [4:0] limit_wr_data = '0;
  logic       clr_seen = 1'b0;
  logic [3:0] starv, starv_pick, starv_seen;
  logic       any_starv;
  logic [4:0] limit;

  int   errors = 0;
  int   checks = 0;
  out_t sb[$];
  out_t got, exp_v;

  sparc_ifu_starv_mon #(.NUM_THR(4), .CTR_W(5), .DEF_LIMIT(24)) dut (
    .clk(clk), .reset(reset), .thr_wait(thr_wait), .thr_grant(thr_grant),
    .limit_wr_en(limit_wr_en), .limit_wr_data(limit_wr_data), .clr_seen(clr_seen),
    .starv(starv), .starv_pick(starv_pick), .any_starv(any_starv),
    .starv_seen(starv_seen), .limit(limit)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(logic [3:0] s, logic [3:0] p, logic a, logic [3:0] sn, logic [4:0] l);
    mk = '{starv: s, pick: p, any: a, seen: sn, limit: l};
  endfunction

  function automatic out_t obs();
    obs = '{starv: starv, pick: starv_pick, any: any_starv, seen: starv_seen, limit: limit};
  endfunction

  function automatic string fmt(out_t v);
    fmt = $sformatf("starv=%b pick=%b any=%b seen=%b limit=%0d", v.starv, v.pick, v.any, v.seen, v.limit);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] w, input logic [3:0] g, input logic wr,
                       input logic [4:0] wd, input logic clr, input logic rst);
    thr_wait = w; thr_grant = g; limit_wr_en = wr; limit_wr_data = wd; clr_seen = clr; reset = rst;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd24));
    do_reset();
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_state: got %s, want %s", fmt(got), fmt(exp_v)); end
  endtask

  task automatic test_starve_basic();
    drive(4'b0001, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd24));
    step(23);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL basic_23_waits: got %s, want %s", fmt(got), fmt(exp_v)); end
    sb.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL basic_24_waits: got %s, want %s", fmt(got), fmt(exp_v)); end
    sb.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL basic_seen_set: got %s, want %s", fmt(got), fmt(exp_v)); end
    // Grant together with wait: grant wins and the counter clears.
    drive(4'b0001, 4'b0001, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0001, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL basic_grant_clears: got %s, want %s", fmt(got), fmt(exp_v)); end
  endtask

  task automatic test_broken_wait();
    drive(4'b0010, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
    step(20);
    thr_wait = 4'b0000;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0001, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL broken_idle_cycle: got %s, want %s", fmt(got), fmt(exp_v)); end
    thr_wait = 4'b0010;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0001, 5'd24));
    step(23);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL broken_23_more: got %s, want %s", fmt(got), fmt(exp_v)); end
    sb.push_back(mk(4'b0010, 4'b0010, 1'b1, 4'b0001, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL broken_24_more: got %s, want %s", fmt(got), fmt(exp_v)); end
    thr_grant = 4'b0010;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0011, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL broken_grant: got %s, want %s", fmt(got), fmt(exp_v)); end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(4'b1010, 4'b0000, 1'b1, 5'd2, 1'b0, 1'b0);
    step(1);
    limit_wr_en = 1'b0;
    sb.push_back(mk(4'b1010, 4'b0010, 1'b1, 4'b0000, 5'd2));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rr_pick_t1: got %s, want %s", fmt(got), fmt(exp_v)); end
    thr_grant = 4'b0010;
    sb.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b1010, 5'd2));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rr_pick_t3: got %s, want %s", fmt(got), fmt(exp_v)); end
    thr_grant = 4'b1000;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b1010, 5'd2));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rr_grant_t3: got %s, want %s", fmt(got), fmt(exp_v)); end
    // Threads 1 and 2 starve: a wrapped pointer (0) picks 1, a stale one (2) would pick 2.
    drive(4'b0110, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0110, 4'b0010, 1'b1, 4'b1010, 5'd2));
    step(2);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rr_wrapped_ptr: got %s, want %s", fmt(got), fmt(exp_v)); end
    thr_grant = 4'b0010;
    sb.push_back(mk(4'b0100, 4'b0100, 1'b1, 4'b1110, 5'd2));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rr_advance_to_t2: got %s, want %s", fmt(got), fmt(exp_v)); end
  endtask

  task automatic test_saturation_limit();
    do_reset();
    drive(4'b0001, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 5'd24));
    step(40);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sat_40_waits: got %s, want %s", fmt(got), fmt(exp_v)); end
    limit_wr_en = 1'b1; limit_wr_data = 5'd0;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0001, 5'd0));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sat_limit_0: got %s, want %s", fmt(got), fmt(exp_v)); end
    limit_wr_data = 5'd31;
    sb.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 5'd31));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sat_limit_31: got %s, want %s", fmt(got), fmt(exp_v)); end
    limit_wr_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(4'b0100, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0100, 4'b0100, 1'b1, 4'b0000, 5'd24));
    step(24);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sim_t2_starves: got %s, want %s", fmt(got), fmt(exp_v)); end
    step(1);
    clr_seen = 1'b1;
    sb.push_back(mk(4'b0100, 4'b0100, 1'b1, 4'b0100, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sim_clr_vs_set: got %s, want %s", fmt(got), fmt(exp_v)); end
    thr_wait = 4'b0000;
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0100, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sim_clr_last_starv: got %s, want %s", fmt(got), fmt(exp_v)); end
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sim_clr_done: got %s, want %s", fmt(got), fmt(exp_v)); end
    drive(4'b1000, 4'b1000, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd24));
    step(30);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sim_grant_and_wait: got %s, want %s", fmt(got), fmt(exp_v)); end
  endtask

  task automatic test_reset_mid();
    drive(4'b0011, 4'b0000, 1'b1, 5'd3, 1'b0, 1'b0);
    step(1);
    limit_wr_en = 1'b0;
    sb.push_back(mk(4'b0011, 4'b0001, 1'b1, 4'b0000, 5'd3));
    step(2);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL mid_two_starve: got %s, want %s", fmt(got), fmt(exp_v)); end
    sb.push_back(mk(4'b0011, 4'b0001, 1'b1, 4'b0011, 5'd3));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL mid_seen: got %s, want %s", fmt(got), fmt(exp_v)); end
    drive(4'b0011, 4'b0000, 1'b1, 5'd7, 1'b0, 1'b1);
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL mid_reset: got %s, want %s", fmt(got), fmt(exp_v)); end
    drive(4'b0011, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0);
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd24));
    step(1);
    got = obs(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL mid_after_reset: got %s, want %s", fmt(got), fmt(exp_v)); end
  endtask

  initial begin
    test_reset();
    test_starve_basic();
    test_broken_wait();
    test_round_robin();
    test_saturation_limit();
    test_simultaneous();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
